// File: rtl/nibble_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_sched
// Brief    : Round-robin shared nibble-serial adder built from a 4-bit slice.
// Revision : 1.0
// ============================================================================

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [NW-1:0] C_LAST_NIB = NW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NIB-1:0][3:0]   a_q, a_d;
    logic [NIB-1:0][3:0]   b_q, b_d;
    logic [NIB-1:0][3:0]   sum_q, sum_d;
    logic                  carry_q, carry_d;
    logic [NW-1:0]         nib_q, nib_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic                  cout_q, cout_d;

    logic [3:0]            w_slice_a, w_slice_b, w_slice_s;
    logic [4:0]            w_chain;
    logic                  w_grant0, w_grant1;

    assign w_slice_a  = a_q[nib_q];
    assign w_slice_b  = b_q[nib_q];
    assign w_chain[0] = carry_q;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_fa
            full_adder u_fa (
                .a_i (w_slice_a[i]),
                .b_i (w_slice_b[i]),
                .c_i (w_chain[i]),
                .s_o (w_slice_s[i]),
                .c_o (w_chain[i+1])
            );
        end
    endgenerate

    // On contention the requester that did not win last time is favoured.
    assign w_grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign w_grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        nib_d        = nib_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cout_d       = cout_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_grant0 | w_grant1) begin
                    req0_ready   = w_grant0;
                    req1_ready   = w_grant1;
                    a_d          = w_grant1 ? req1_a : req0_a;
                    b_d          = w_grant1 ? req1_b : req0_b;
                    id_d         = w_grant1;
                    last_grant_d = w_grant1;
                    carry_d      = 1'b0;
                    nib_d        = '0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                sum_d[nib_q] = w_slice_s;
                carry_d      = w_chain[4];
                nib_d        = nib_q + NW'(1);
                if (nib_q == C_LAST_NIB) begin
                    cout_d  = w_chain[4];
                    nib_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            nib_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            nib_q        <= nib_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cout_q       <= cout_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_add_sched
// Brief    : Directed-vector bench for the shared nibble-serial adder.
// Revision : 1.0
// ============================================================================

module tb_nibble_add_sched;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid, rsp_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready, rsp_valid, rsp_cout, rsp_id, busy;
    logic [WIDTH-1:0] rsp_sum;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_last = 1'b1;

    nibble_add_sched #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the combinational grant, takes the accept edge, drops the winner's valid.
    task automatic accept(input string tag, input logic eid);
        #1;
        check({tag, " req0_ready"}, req0_ready, eid == 1'b0);
        check({tag, " req1_ready"}, req1_ready, eid == 1'b1);
        tick();
        if (eid) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
        exp_last = eid;
        #1;
        check({tag, " busy after accept"}, busy, 1'b1);
        check({tag, " readies in CALC"}, {req0_ready, req1_ready}, 2'b00);
    endtask

    task automatic wait_result(input string tag, input logic [WIDTH-1:0] es,
                               input logic ec, input logic eid);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, NIB);
        check({tag, " sum"}, rsp_sum, es);
        check({tag, " cout"}, rsp_cout, ec);
        check({tag, " id"}, rsp_id, eid);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " valid after take"}, rsp_valid, 1'b0);
        check({tag, " busy after take"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_last = 1'b1;
        #1;
        check("reset valid", rsp_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset sum", rsp_sum, '0);
        check("reset cout/id", {rsp_cout, rsp_id}, 2'b00);
        check("reset readies", {req0_ready, req1_ready}, 2'b00);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {req0_valid, req1_valid, rsp_ready} = 3'b000;
        {req0_a, req0_b, req1_a, req1_b} = '0;
        tick();
        tick();
        do_reset();

        // Single requester, no carries.
        req0_a = 16'h1234; req0_b = 16'h4321; req0_valid = 1'b1;
        accept("t1", 1'b0);
        wait_result("t1", 16'h5555, 1'b0, 1'b0);
        release_rsp("t1");

        // last_grant must return to 1 on reset, so req0 wins the tie.
        tick();
        do_reset();
        req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_valid = 1'b1;
        req1_a = 16'h8000; req1_b = 16'h8000; req1_valid = 1'b1;
        accept("t3a", 1'b0);
        wait_result("t3a", 16'h100E, 1'b0, 1'b0);
        release_rsp("t3a");
        accept("t3b", 1'b1);
        wait_result("t3b", 16'h0000, 1'b1, 1'b1);
        release_rsp("t3b");
        req0_a = 16'h0001; req0_b = 16'h0001; req0_valid = 1'b1;
        req1_a = 16'h0003; req1_b = 16'h0004; req1_valid = 1'b1;
        accept("t3c", 1'b0);
        wait_result("t3c", 16'h0002, 1'b0, 1'b0);
        release_rsp("t3c");
        accept("t3d", 1'b1);
        wait_result("t3d", 16'h0007, 1'b0, 1'b1);
        release_rsp("t3d");

        // Full ripple across every nibble.
        req1_a = 16'hFFFF; req1_b = 16'h0001; req1_valid = 1'b1;
        accept("t2", 1'b1);
        wait_result("t2", 16'h0000, 1'b1, 1'b1);
        release_rsp("t2");

        // Backpressure in DONE with both requesters waiting.
        req0_a = 16'h1111; req0_b = 16'h2222; req0_valid = 1'b1;
        accept("t4", 1'b0);
        wait_result("t4", 16'h3333, 1'b0, 1'b0);
        req0_a = 16'h0F00; req0_b = 16'h0100; req0_valid = 1'b1;
        req1_a = 16'h7FFF; req1_b = 16'h0001; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4 hold valid", rsp_valid, 1'b1);
            check("t4 hold sum", rsp_sum, 16'h3333);
            check("t4 hold busy", busy, 1'b1);
            check("t4 hold readies", {req0_ready, req1_ready}, 2'b00);
        end
        release_rsp("t4");
        check("t4 sum held after take", rsp_sum, 16'h3333);
        accept("t4b", 1'b1);
        wait_result("t4b", 16'h8000, 1'b0, 1'b1);
        release_rsp("t4b");
        accept("t4c", 1'b0);
        wait_result("t4c", 16'h1000, 1'b0, 1'b0);
        release_rsp("t4c");

        // Reset mid-operation discards the work.
        req0_a = 16'hABCD; req0_b = 16'h1111; req0_valid = 1'b1;
        accept("t5", 1'b0);
        tick();
        tick();
        do_reset();
        check("t5 no late result", rsp_valid, 1'b0);
        req1_a = 16'h0001; req1_b = 16'h0002; req1_valid = 1'b1;
        accept("t5b", 1'b1);
        wait_result("t5b", 16'h0003, 1'b0, 1'b1);
        release_rsp("t5b");
        req0_a = 16'h0010; req0_b = 16'h0020; req0_valid = 1'b1;
        req1_a = 16'h0100; req1_b = 16'h0200; req1_valid = 1'b1;
        accept("t5c", 1'b0);
        wait_result("t5c", 16'h0030, 1'b0, 1'b0);
        release_rsp("t5c");
        accept("t5d", 1'b1);
        wait_result("t5d", 16'h0300, 1'b0, 1'b1);
        release_rsp("t5d");

        // Randomised operands and request patterns against a+b.
        for (int i = 0; i < 60; i++) begin
            logic             v0, v1, g;
            logic [WIDTH:0]   e0, e1, ex;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
            req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
            e0 = {1'b0, req0_a} + {1'b0, req0_b};
            e1 = {1'b0, req1_a} + {1'b0, req1_b};
            req0_valid = v0;
            req1_valid = v1;
            g  = (v0 && v1) ? ~exp_last : v1;
            ex = g ? e1 : e0;
            accept("rnd", g);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            wait_result("rnd", ex[WIDTH-1:0], ex[WIDTH], g);
            repeat ($urandom_range(0, 3)) tick();
            check("rnd valid held", rsp_valid, 1'b1);
            release_rsp("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
Shared nibble-serial adder scheduler. Two requesters compete for one 4-bit add slice built from four full_adder cells. The block arbitrates round-robin, accepts a WIDTH-bit operand pair, and sequences the slice over WIDTH/4 cycles with a registered inter-nibble carry. It returns sum, carry-out and requester ID through a valid/ready response port. It sits between operand producers and a single result consumer.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 8
NIB, WIDTH/4, derived localparam giving the nibble count per operation; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 pair accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  requester 1 pair accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes the result
rsp_sum  output  WIDTH  (A+B) mod 2^WIDTH
rsp_cout  output  1  carry out of the MSB
rsp_id  output  1  requester that issued the result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; operand, sum, carry and nibble-count registers cleared; last_grant=1 so requester 0 wins first. Any in-flight operation is discarded and not replayed.
- States: IDLE, CALC, DONE.
- IDLE, arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - Grant is combinational: reqX_ready=1 for the granted requester only, in the same cycle.
- IDLE, accept edge: latch A/B, rsp_id=granted ID, last_grant=granted ID, carry=0, nib_cnt=0, state=CALC.
- IDLE with no valid: stay in IDLE.
- Both reqX_ready are 0 in CALC and DONE.
- CALC, each edge:
  - Slice computes A[4k+3:4k] + B[4k+3:4k] + carry for k=nib_cnt.
  - The 4-bit result is written into sum[4k+3:4k].
  - carry takes the slice carry-out and nib_cnt increments.
  - When k=NIB-1: state=DONE, rsp_cout=slice carry-out, rsp_valid=1.
- Latency: rsp_valid rises exactly NIB clock edges after the accept edge (4 for WIDTH=16). Each nibble takes exactly one cycle; there is no early termination.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are held stable.
  - rsp_ready=1 at an edge: rsp_valid=0, state=IDLE.
  - No new request is accepted in the same edge. Minimum spacing between accepts is NIB+2 cycles.
- Output hold: rsp_sum, rsp_cout and rsp_id keep their last values after rsp_valid drops and are only updated by the next operation. Consumers must qualify them with rsp_valid.
- Arithmetic: unsigned, modulo 2^WIDTH; rsp_cout is the true carry out of bit WIDTH-1.
- Protocol: requesters hold valid and operands until ready. A requester dropping valid while not granted causes no state change.
- busy=1 in CALC and DONE.

Test Plan:
1. WIDTH=16, req0 only, a=0x1234, b=0x4321 -> req0_ready=1 in the accept cycle; rsp_valid 4 edges later; sum=0x5555, cout=0, id=0.
2. req1 only, a=0xFFFF, b=0x0001 -> full carry ripple across all nibbles; sum=0x0000, cout=1, id=1.
3. Both valid out of reset: req0 (0x00FF+0x0F0F) granted first -> 0x100E, id=0. Then req1 (0x8000+0x8000) -> 0x0000, cout=1, id=1. Both valid again -> req0 is granted (strict alternation).
4. Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, busy=1, both readies 0. Release -> IDLE one edge later, with a new accept possible in the next cycle.
5. Assert rst_n low two edges into CALC (a=0xABCD, b=0x1111) -> all outputs 0 immediately and the operation is lost. After release, req1 (0x0001+0x0002) gives 0x0003; a subsequent simultaneous request is granted to req0.
6. 500 random operations with random valid/ready toggling on both ports, checked against a scoreboard of (A+B), ID and ordering -> zero mismatches and no lost or duplicated results.
